// File: rtl/demux_sched_pkg.sv
// Shared types and helpers for the 1x8 demux scheduler.
package demux_sched_pkg;

  localparam int unsigned NCH   = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } state_e;

  // Increment that sticks at max. Values are carried in 32 bits, so counters must be <= 32 wide.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction

  function automatic logic [NCH-1:0] onehot(input logic [SEL_W-1:0] sel);
    return NCH'(1) << sel;
  endfunction

endpackage

// File: rtl/demux_sched_1x8_rr_pick.sv
// Rotate-priority search: first set mask bit strictly after ptr, wrapping, ptr itself last.
module rr_pick
  import demux_sched_pkg::*;
(
  input  logic [SEL_W-1:0] ptr,
  input  logic [NCH-1:0]   mask,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  // Walk from the farthest candidate (ptr itself) down to ptr+1 so the nearest match wins.
  always_comb begin
    logic [SEL_W-1:0] cand;
    idx   = '0;
    found = 1'b0;
    for (int i = NCH; i >= 1; i--) begin
      cand = ptr + SEL_W'(i);
      if (mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_sched_1x8.sv
// Scheduler for a 1-to-8 demux: one-entry output register, round-robin or directed target.
module demux_sched_1x8
  import demux_sched_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic [SEL_W-1:0] in_dest,
  output logic             in_ready,
  input  logic             mode,
  input  logic [NCH-1:0]   ch_en,
  output logic [NCH-1:0]   out_valid,
  output logic [DW-1:0]    out_data,
  input  logic [NCH-1:0]   out_ready,
  output logic [SEL_W-1:0] cur_sel,
  output logic             busy,
  output logic [CW-1:0]    sent_cnt,
  output logic [CW-1:0]    drop_cnt
);

  localparam logic [31:0] CntMax = 32'({CW{1'b1}});

  state_e           state_q, state_d;
  logic [NCH-1:0]   out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    sent_cnt_q, sent_cnt_d;
  logic [CW-1:0]    drop_cnt_q, drop_cnt_d;

  logic             complete;
  logic             slot_free;
  logic             accept;
  logic             load;
  logic             drop;
  logic [SEL_W-1:0] search_ptr;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_found;
  logic [SEL_W-1:0] target;

  // The round-robin search must already see the pointer moved by a same-cycle completion.
  rr_pick u_rr_pick (
    .ptr   (search_ptr),
    .mask  (ch_en),
    .idx   (rr_idx),
    .found (rr_found)
  );

  // Handshake decode: completion, accept, and whether the accepted word is kept or dropped.
  always_comb begin
    complete   = (state_q == StSend) && out_ready[cur_sel_q];
    slot_free  = (state_q == StIdle) || complete;
    search_ptr = complete ? cur_sel_q : rr_ptr_q;
    // Nothing is taken while reset is held.
    if (rst) begin
      in_ready = 1'b0;
    end else if (mode) begin
      in_ready = slot_free;
    end else begin
      in_ready = slot_free && rr_found;
    end
    accept = in_valid && in_ready;
    target = mode ? in_dest : rr_idx;
    load   = accept && ch_en[target];
    drop   = accept && !ch_en[target];
  end

  // Next-state for the held word, pointer and statistics.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cur_sel_d   = cur_sel_q;
    rr_ptr_d    = complete ? cur_sel_q : rr_ptr_q;
    sent_cnt_d  = complete ? CW'(sat_inc(32'(sent_cnt_q), CntMax)) : sent_cnt_q;
    drop_cnt_d  = drop ? CW'(sat_inc(32'(drop_cnt_q), CntMax)) : drop_cnt_q;
    if (load) begin
      state_d     = StSend;
      out_valid_d = onehot(target);
      out_data_d  = in_data;
      cur_sel_d   = target;
    end else if (complete) begin
      state_d     = StIdle;
      out_valid_d = '0;
    end
  end

  // State registers; reset drops any held word at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= '0;
      out_data_q  <= '0;
      cur_sel_q   <= '0;
      rr_ptr_q    <= SEL_W'(NCH - 1);
      sent_cnt_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cur_sel_q   <= cur_sel_d;
      rr_ptr_q    <= rr_ptr_d;
      sent_cnt_q  <= sent_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    out_valid = out_valid_q;
    out_data  = out_data_q;
    cur_sel   = cur_sel_q;
    busy      = (state_q == StSend);
    sent_cnt  = sent_cnt_q;
    drop_cnt  = drop_cnt_q;
  end

endmodule
